exp_flush_ctrl: RTL and testbench
=================================

// Module: exp_flush_ctrl
// PURPOSE
//  MEM-stage exception/ERET sequencer for the 5-stage MIPS pipeline. Prioritises MEM-stage exception flags
//  and drives is_exp into the MEM write-kill mux. Flushes IF/ID/EX/MEM pipeline registers for a fixed
//  window, commits EPC/Cause/BadVAddr/EXL to CP0, then redirects fetch to the handler vector or to EPC (ERET).
// PARAMETERS
//  EXC_VECTOR    32'hBFC0_0380  handler entry PC
//  FLUSH_CYCLES  2              cycles flush_o held high (1..15)
// PORTS
//  clk            in   1   rising-edge clock
//  resetn         in   1   asynchronous, active-low reset
//  mem_valid      in   1   MEM stage holds a real instruction
//  mem_stall      in   1   MEM stage stalled (d-cache/mult); no decision taken this cycle
//  mem_pc         in   32  PC of MEM instruction
//  mem_in_ds      in   1   MEM instruction sits in a branch delay slot
//  mem_badvaddr   in   32  faulting data address (or mem_pc for fetch fault)
//  exc_flags      in   7   {adel_if, ri, ov, sys, bp, adel_ld, ades} one-hot-or-more
//  mem_eret       in   1   MEM instruction is ERET
//  cp0_epc        in   32  current CP0 EPC (ERET target)
//  cp0_exl        in   1   Status.EXL
//  is_exp         out  1   kill MEM-stage regwrite/memwrite/hi/lo/cp0 writes
//  flush_o        out  1   clear IF/ID/EX/MEM pipeline registers
//  pc_redirect    out  1   one-cycle fetch redirect strobe
//  redirect_pc    out  32  redirect target
//  cp0_exc_we     out  1   one-cycle CP0 exception commit strobe
//  cp0_epc_o      out  32  EPC value to write
//  cp0_excode     out  5   Cause.ExcCode
//  cp0_bd         out  1   Cause.BD
//  cp0_badvaddr   out  32  BadVAddr value
//  cp0_badv_we    out  1   BadVAddr write enable (address errors only)
//  cp0_eret_clr   out  1   one-cycle strobe clearing Status.EXL
// BEHAVIOUR
//  States IDLE -> FLUSH -> REDIR -> IDLE; 4-bit flush counter.
//  trigger = mem_valid & ~mem_stall & (|exc_flags | mem_eret), sampled only in IDLE.
//  is_exp: combinational = trigger in IDLE; registered 1 throughout FLUSH and REDIR.
//  IDLE + trigger: next edge -> FLUSH, cnt<=FLUSH_CYCLES-1, latch target/CP0 fields, pulse cp0_exc_we or cp0_eret_clr.
//  Exception beats ERET when both set (ERET then not executed). Priority high->low:
//   adel_if(4) > ri(10) > ov(12) > sys(8) > bp(9) > adel_ld(4) > ades(5); ExcCode in brackets.
//  EPC = mem_in_ds ? mem_pc-32'd4 (mod 2^32) : mem_pc; cp0_bd = mem_in_ds.
//  cp0_badv_we=1 only for adel_if/adel_ld/ades; badvaddr = mem_badvaddr.
//  Exception target = EXC_VECTOR; ERET target = cp0_epc sampled at trigger.
//  cp0_exl=1 at exception: EPC/BD not updated (cp0_exc_we still pulses with epc/bd fields held; CP0 ignores them).
//  FLUSH: flush_o=1; cnt decrements; at cnt==0 -> REDIR. mem_stall ignored.
//  REDIR: pc_redirect=1, redirect_pc valid, flush_o=1; next edge -> IDLE.
//  Triggers arriving in FLUSH/REDIR are dropped (flushed instructions).
//  Latency: trigger edge -> redirect strobe = FLUSH_CYCLES+1 cycles.
//  Reset (any time, incl. mid-sequence): state=IDLE, all outputs 0, redirect_pc=EXC_VECTOR, latched regs 0.
// CONFIGURATION
//  EXP_INT_EN defined: adds ports int_pending in 1 and cp0_ie in 1; interrupt (ExcCode 0) has top
//   priority, taken when int_pending & cp0_ie & ~cp0_exl & mem_valid & ~mem_stall; EPC=mem_pc (BD rule applies).
//  EXP_INT_EN undefined: ports absent, interrupts never taken; all other behaviour identical.
// TESTING
//  ov=1, mem_pc=0x8000_0100, in_ds=0 -> is_exp same cycle; excode=12, epc=0x8000_0100; redirect 0xBFC0_0380 at +3.
//  ades=1, in_ds=1, pc=0x8000_0204, badvaddr=0x1003 -> epc=0x8000_0200, bd=1, badv_we=1, excode=5.
//  ri=1 and sys=1 and mem_eret=1 same cycle -> excode=10, no cp0_eret_clr, target EXC_VECTOR.
//  mem_eret=1, cp0_epc=0x8000_0040 -> cp0_eret_clr pulse, redirect_pc=0x8000_0040 after FLUSH_CYCLES+1.
//  ov=1 with mem_stall=1 for 3 cycles -> no trigger until stall drops; resetn low in FLUSH -> all outputs 0 immediately.
//  EXP_INT_EN: int_pending=1, cp0_ie=1, ov=1 -> excode=0; with cp0_exl=1 -> excode=12.

Source files
------------

// File: rtl/exp_flush_ctrl.sv
// exp_flush_ctrl: MEM-stage exception / ERET sequencer.
// Picks the highest-priority MEM exception (or ERET) and kills the MEM writes.
// Flushes IF/ID/EX/MEM for FLUSH_CYCLES cycles and commits the CP0 exception fields.
// It then redirects fetch to EXC_VECTOR or, for ERET, to the sampled EPC.
// Optional feature macro: EXP_INT_EN adds the int_pending/cp0_ie ports and
// the interrupt request, which has top priority. When the macro is undefined,
// interrupts are never taken.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | watching MEM for a trigger; is_exp follows trigger
// S_FLUSH | flush_o held, down-counter runs to terminal count 0
// S_REDIR | one-cycle fetch redirect, flush_o still held
module exp_flush_ctrl #(
    parameter logic [31:0] EXC_VECTOR   = 32'hBFC0_0380,
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        mem_valid,
    input  logic        mem_stall,
    input  logic [31:0] mem_pc,
    input  logic        mem_in_ds,
    input  logic [31:0] mem_badvaddr,
    input  logic [6:0]  exc_flags,
    input  logic        mem_eret,
    input  logic [31:0] cp0_epc,
    input  logic        cp0_exl,
`ifdef EXP_INT_EN
    input  logic        int_pending,
    input  logic        cp0_ie,
`endif
    output logic        is_exp,
    output logic        flush_o,
    output logic        pc_redirect,
    output logic [31:0] redirect_pc,
    output logic        cp0_exc_we,
    output logic [31:0] cp0_epc_o,
    output logic [4:0]  cp0_excode,
    output logic        cp0_bd,
    output logic [31:0] cp0_badvaddr,
    output logic        cp0_badv_we,
    output logic        cp0_eret_clr
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FLUSH = 2'd1,
        S_REDIR = 2'd2
    } state_t;

    localparam logic [3:0] CNT_LOAD = 4'(FLUSH_CYCLES - 1);

    // exception codes written into Cause.ExcCode
    localparam logic [4:0] EXC_INT  = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;
    localparam logic [4:0] EXC_SYS  = 5'd8;
    localparam logic [4:0] EXC_BP   = 5'd9;
    localparam logic [4:0] EXC_RI   = 5'd10;
    localparam logic [4:0] EXC_OV   = 5'd12;

    state_t      state;
    state_t      state_nxt;
    logic [3:0]  cnt;
    logic [3:0]  cnt_nxt;

    logic        int_take;
    logic        exc_hit;
    logic [4:0]  exc_code;
    logic        addr_err;
    logic        trigger;
    logic [31:0] epc_calc;

    // interrupt request qualified by Status (absent in the default build)
`ifdef EXP_INT_EN
    assign int_take = int_pending & cp0_ie & ~cp0_exl;
`else
    assign int_take = 1'b0;
`endif

    // priority encoder over the interrupt and the MEM exception flags
    always_comb begin
        exc_hit  = 1'b1;
        exc_code = EXC_INT;
        addr_err = 1'b0;
        if (int_take) begin
            exc_code = EXC_INT;
        end else if (exc_flags[6]) begin
            exc_code = EXC_ADEL;
            addr_err = 1'b1;
        end else if (exc_flags[5]) begin
            exc_code = EXC_RI;
        end else if (exc_flags[4]) begin
            exc_code = EXC_OV;
        end else if (exc_flags[3]) begin
            exc_code = EXC_SYS;
        end else if (exc_flags[2]) begin
            exc_code = EXC_BP;
        end else if (exc_flags[1]) begin
            exc_code = EXC_ADEL;
            addr_err = 1'b1;
        end else if (exc_flags[0]) begin
            exc_code = EXC_ADES;
            addr_err = 1'b1;
        end else begin
            exc_hit = 1'b0;
        end
    end

    // Gating with resetn keeps is_exp low while reset is asserted, even
    // though the state register already reads IDLE.
    assign trigger  = resetn & mem_valid & ~mem_stall & (exc_hit | mem_eret);
    assign epc_calc = mem_in_ds ? (mem_pc - 32'd4) : mem_pc;

    // state register and flush down-counter
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= S_IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // next-state logic and the state-decoded outputs
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        is_exp      = 1'b0;
        flush_o     = 1'b0;
        pc_redirect = 1'b0;
        case (state)
            S_IDLE: begin
                is_exp = trigger;
                if (trigger) begin
                    state_nxt = S_FLUSH;
                    cnt_nxt   = CNT_LOAD;
                end
            end
            S_FLUSH: begin
                is_exp  = 1'b1;
                flush_o = 1'b1;
                if (cnt == 4'd0) begin
                    state_nxt = S_REDIR;
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            S_REDIR: begin
                is_exp      = 1'b1;
                flush_o     = 1'b1;
                pc_redirect = 1'b1;
                state_nxt   = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Latch the redirect target and the CP0 commit fields on an accepted
    // trigger. The commit strobes last one cycle. An exception beats a
    // simultaneous ERET. With EXL already set, EPC and BD keep their old
    // values because CP0 ignores them anyway.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            redirect_pc  <= EXC_VECTOR;
            cp0_exc_we   <= 1'b0;
            cp0_eret_clr <= 1'b0;
            cp0_badv_we  <= 1'b0;
            cp0_epc_o    <= 32'd0;
            cp0_excode   <= 5'd0;
            cp0_bd       <= 1'b0;
            cp0_badvaddr <= 32'd0;
        end else begin
            cp0_exc_we   <= 1'b0;
            cp0_eret_clr <= 1'b0;
            cp0_badv_we  <= 1'b0;
            if (state == S_IDLE && trigger) begin
                if (exc_hit) begin
                    redirect_pc  <= EXC_VECTOR;
                    cp0_exc_we   <= 1'b1;
                    cp0_badv_we  <= addr_err;
                    cp0_excode   <= exc_code;
                    cp0_badvaddr <= mem_badvaddr;
                    if (!cp0_exl) begin
                        cp0_epc_o <= epc_calc;
                        cp0_bd    <= mem_in_ds;
                    end
                end else begin
                    redirect_pc  <= cp0_epc;
                    cp0_eret_clr <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_exp_flush_ctrl.sv
// Scoreboard bench for exp_flush_ctrl. A reference model works out each
// accepted trigger from the priority table. It queues the expected CP0 commit
// and redirect events, and a separate monitor pops and compares them when the
// DUT strobes.
module tb_exp_flush_ctrl;

    localparam logic [31:0] VEC = 32'hBFC0_0380;
    localparam int          FC  = 2;

    logic        clk = 1'b0;
    logic        resetn;
    logic        mem_valid, mem_stall, mem_in_ds, mem_eret, cp0_exl;
    logic [31:0] mem_pc, mem_badvaddr, cp0_epc;
    logic [6:0]  exc_flags;
`ifdef EXP_INT_EN
    logic        int_pending = 1'b0;
    logic        cp0_ie = 1'b0;
`endif
    logic        is_exp, flush_o, pc_redirect, cp0_exc_we, cp0_bd, cp0_badv_we, cp0_eret_clr;
    logic [31:0] redirect_pc, cp0_epc_o, cp0_badvaddr;
    logic [4:0]  cp0_excode;

    exp_flush_ctrl #(.EXC_VECTOR(VEC), .FLUSH_CYCLES(FC)) dut (
        .clk(clk), .resetn(resetn),
        .mem_valid(mem_valid), .mem_stall(mem_stall), .mem_pc(mem_pc),
        .mem_in_ds(mem_in_ds), .mem_badvaddr(mem_badvaddr), .exc_flags(exc_flags),
        .mem_eret(mem_eret), .cp0_epc(cp0_epc), .cp0_exl(cp0_exl),
`ifdef EXP_INT_EN
        .int_pending(int_pending), .cp0_ie(cp0_ie),
`endif
        .is_exp(is_exp), .flush_o(flush_o), .pc_redirect(pc_redirect),
        .redirect_pc(redirect_pc), .cp0_exc_we(cp0_exc_we), .cp0_epc_o(cp0_epc_o),
        .cp0_excode(cp0_excode), .cp0_bd(cp0_bd), .cp0_badvaddr(cp0_badvaddr),
        .cp0_badv_we(cp0_badv_we), .cp0_eret_clr(cp0_eret_clr)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    typedef struct {
        int          cyc;
        logic        eret;
        logic [4:0]  code;
        logic [31:0] epc;
        logic        bd;
        logic        badv_we;
        logic [31:0] badv;
    } commit_t;

    typedef struct {
        int          cyc;
        logic [31:0] pc;
    } redir_t;

    commit_t qc[$];
    redir_t  qr[$];

    // reference model state
    int          busy_from = -1;
    int          busy_to   = -2;
    logic [31:0] m_epc = 32'd0;
    logic        m_bd  = 1'b0;
    logic        m_busy, m_trig, m_badv;
    int          m_code;
    int          pri_code[7] = '{4, 10, 12, 8, 9, 4, 5};
    logic        pri_addr[7] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

    // Reference model: it decides from the architectural rules whether this
    // cycle triggers, and queues the expected commit and redirect events.
    always @(negedge clk) begin
        if (!resetn) begin
            qc.delete();
            qr.delete();
            busy_from = -1;
            busy_to   = -2;
            m_epc     = 32'd0;
            m_bd      = 1'b0;
        end else begin
            m_busy = (cyc >= busy_from) && (cyc <= busy_to);
            m_code = -1;
            m_badv = 1'b0;
`ifdef EXP_INT_EN
            if (int_pending && cp0_ie && !cp0_exl) m_code = 0;
`endif
            for (int i = 0; i < 7; i++) begin
                if (m_code < 0 && exc_flags[6-i]) begin
                    m_code = pri_code[i];
                    m_badv = pri_addr[i];
                end
            end
            m_trig = mem_valid && !mem_stall && (m_code >= 0 || mem_eret) && !m_busy;
            check("is_exp", {31'd0, is_exp}, {31'd0, m_busy || m_trig});
            check("flush_o", {31'd0, flush_o}, {31'd0, m_busy});
            if (m_trig) begin
                busy_from = cyc + 1;
                busy_to   = cyc + FC + 1;
                if (m_code >= 0) begin
                    if (!cp0_exl) begin
                        m_epc = mem_in_ds ? mem_pc - 32'd4 : mem_pc;
                        m_bd  = mem_in_ds;
                    end
                    qc.push_back(commit_t'{cyc + 1, 1'b0, m_code[4:0], m_epc, m_bd, m_badv, mem_badvaddr});
                    qr.push_back(redir_t'{cyc + FC + 1, VEC});
                end else begin
                    qc.push_back(commit_t'{cyc + 1, 1'b1, 5'd0, 32'd0, 1'b0, 1'b0, 32'd0});
                    qr.push_back(redir_t'{cyc + FC + 1, cp0_epc});
                end
            end
        end
    end

    // Monitor: it pops the expected events when the DUT strobes and flags
    // missing or spurious strobes.
    commit_t c;
    redir_t  r;
    always @(negedge clk) begin
        if (resetn) begin
            if (cp0_exc_we || cp0_eret_clr) begin
                if (qc.size() == 0) begin
                    check("spurious_commit", {30'd0, cp0_exc_we, cp0_eret_clr}, 32'd0);
                end else begin
                    c = qc.pop_front();
                    check("commit_cycle", cyc, c.cyc);
                    check("commit_kind", {30'd0, cp0_exc_we, cp0_eret_clr}, c.eret ? 32'd1 : 32'd2);
                    if (!c.eret) begin
                        check("excode", {27'd0, cp0_excode}, {27'd0, c.code});
                        check("epc", cp0_epc_o, c.epc);
                        check("bd", {31'd0, cp0_bd}, {31'd0, c.bd});
                        check("badv_we", {31'd0, cp0_badv_we}, {31'd0, c.badv_we});
                        if (c.badv_we) check("badvaddr", cp0_badvaddr, c.badv);
                    end else begin
                        check("badv_we_eret", {31'd0, cp0_badv_we}, 32'd0);
                    end
                end
            end else begin
                check("badv_we_idle", {31'd0, cp0_badv_we}, 32'd0);
                if (qc.size() > 0 && qc[0].cyc < cyc) begin
                    c = qc.pop_front();
                    check("commit_missing", cyc, c.cyc);
                end
            end
            if (pc_redirect) begin
                if (qr.size() == 0) begin
                    check("spurious_redirect", {31'd0, pc_redirect}, 32'd0);
                end else begin
                    r = qr.pop_front();
                    check("redirect_cycle", cyc, r.cyc);
                    check("redirect_pc", redirect_pc, r.pc);
                end
            end else if (qr.size() > 0 && qr[0].cyc < cyc) begin
                r = qr.pop_front();
                check("redirect_missing", cyc, r.cyc);
            end
        end
    end

    task automatic drive(input logic v, input logic st, input logic [31:0] pc, input logic ds,
                         input logic [31:0] bva, input logic [6:0] fl, input logic er,
                         input logic [31:0] epc, input logic exl);
        mem_valid    = v;
        mem_stall    = st;
        mem_pc       = pc;
        mem_in_ds    = ds;
        mem_badvaddr = bva;
        exc_flags    = fl;
        mem_eret     = er;
        cp0_epc      = epc;
        cp0_exl      = exl;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 7'd0, 1'b0, 32'd0, 1'b0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_is_exp"}, {31'd0, is_exp}, 32'd0);
        check({tag, "_flush"}, {31'd0, flush_o}, 32'd0);
        check({tag, "_redirect"}, {31'd0, pc_redirect}, 32'd0);
        check({tag, "_redirect_pc"}, redirect_pc, VEC);
        check({tag, "_strobes"}, {29'd0, cp0_exc_we, cp0_eret_clr, cp0_badv_we}, 32'd0);
        check({tag, "_epc"}, cp0_epc_o, 32'd0);
        check({tag, "_excode"}, {27'd0, cp0_excode}, 32'd0);
        check({tag, "_bd"}, {31'd0, cp0_bd}, 32'd0);
        check({tag, "_badvaddr"}, cp0_badvaddr, 32'd0);
    endtask

    initial begin
        resetn = 1'b0;
        // a live trigger during reset must not reach is_exp
        mem_valid = 1'b1; mem_stall = 1'b0; mem_pc = 32'h8000_0000; mem_in_ds = 1'b0;
        mem_badvaddr = 32'd0; exc_flags = 7'b0010000; mem_eret = 1'b0; cp0_epc = 32'd0; cp0_exl = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("por");
        mem_valid = 1'b0; exc_flags = 7'd0;
        resetn = 1'b1;
        idle(2);

        drive(1'b1, 1'b0, 32'h8000_0100, 1'b0, 32'd0, 7'b0010000, 1'b0, 32'd0, 1'b0);       // ov
        idle(FC + 3);
        drive(1'b1, 1'b0, 32'h8000_0204, 1'b1, 32'h0000_1003, 7'b0000001, 1'b0, 32'd0, 1'b0); // ades in ds
        idle(FC + 3);
        drive(1'b1, 1'b0, 32'h8000_0300, 1'b0, 32'd0, 7'b0101000, 1'b1, 32'h8000_0040, 1'b0); // ri+sys+eret
        idle(FC + 3);
        drive(1'b1, 1'b0, 32'h8000_0400, 1'b0, 32'd0, 7'd0, 1'b1, 32'h8000_0040, 1'b1);       // eret
        idle(FC + 3);
        repeat (3) drive(1'b1, 1'b1, 32'h8000_0500, 1'b0, 32'd0, 7'b0010000, 1'b0, 32'd0, 1'b0); // stalled ov
        drive(1'b1, 1'b0, 32'h8000_0500, 1'b0, 32'd0, 7'b0010000, 1'b0, 32'd0, 1'b0);
        idle(FC + 3);
        drive(1'b1, 1'b0, 32'h8000_0600, 1'b1, 32'd0, 7'b0000100, 1'b0, 32'd0, 1'b1);        // bp with EXL held
        idle(FC + 3);
        drive(1'b1, 1'b0, 32'h0000_0000, 1'b1, 32'h0000_0002, 7'b1000000, 1'b0, 32'd0, 1'b0); // adel_if, pc wraps
        repeat (FC + 1) drive(1'b1, 1'b0, 32'h8000_0700, 1'b0, 32'd0, 7'b0010000, 1'b0, 32'd0, 1'b0); // dropped
        idle(FC + 3);

        // reset in the middle of FLUSH
        drive(1'b1, 1'b0, 32'h8000_0800, 1'b0, 32'd0, 7'b0010000, 1'b0, 32'd0, 1'b0);
        drive(1'b1, 1'b0, 32'h8000_0804, 1'b0, 32'd0, 7'b0010000, 1'b0, 32'd0, 1'b0);
        resetn = 1'b0;
        #1;
        check_reset_outputs("mid_reset");
        @(posedge clk);
        #1;
        resetn = 1'b1;
        idle(2);

`ifdef EXP_INT_EN
        int_pending = 1'b1; cp0_ie = 1'b1;
        drive(1'b1, 1'b0, 32'h8000_0900, 1'b0, 32'd0, 7'b0010000, 1'b0, 32'd0, 1'b0);
        idle(FC + 3);
        drive(1'b1, 1'b0, 32'h8000_0904, 1'b0, 32'd0, 7'b0010000, 1'b0, 32'd0, 1'b1);
        idle(FC + 3);
        int_pending = 1'b0; cp0_ie = 1'b0;
`endif

        for (int i = 0; i < 600; i++) begin
            logic [6:0] fl;
            for (int b = 0; b < 7; b++) fl[b] = ($urandom_range(0, 9) == 0);
`ifdef EXP_INT_EN
            int_pending = ($urandom_range(0, 7) == 0);
            cp0_ie      = $urandom_range(0, 1) == 1;
`endif
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0,
                  {$urandom} & 32'hFFFF_FFFC, $urandom_range(0, 3) == 0, $urandom,
                  fl, $urandom_range(0, 7) == 0, {$urandom} & 32'hFFFF_FFFC,
                  $urandom_range(0, 3) == 0);
        end
`ifdef EXP_INT_EN
        int_pending = 1'b0;
`endif
        idle(FC + 4);
        check("commit_queue_drained", qc.size(), 32'd0);
        check("redirect_queue_drained", qr.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
